// File: rtl/adc_seq_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC frame sequencer:
//   - register offsets of the sigma-delta ADC slave
//   - sequencer FSM state encoding
//   - FIFO entry layout {err, last, ch[1:0], data[15:0]} (20 bits)
//   - small mask helpers used for frame admission and channel walking
// ---------------------------------------------------------------------------
package adc_seq_pkg;

  localparam logic [7:0] REG_CTRL        = 8'h00;
  localparam logic [7:0] REG_STATUS      = 8'h04;
  localparam logic [7:0] REG_DATA_CH0    = 8'h08;
  localparam logic [7:0] REG_DATA_STRIDE = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EN_WR    = 3'd1,
    ST_WAIT_IRQ = 3'd2,
    ST_RD       = 3'd3,
    ST_RD_GAP   = 3'd4,
    ST_DIS_WR   = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic        err;
    logic        last;
    logic [1:0]  ch;
    logic [15:0] data;
  } sample_entry_t;

  localparam int ENTRY_W = $bits(sample_entry_t);

  // Number of channels a frame will push.
  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

  // Lowest selected channel; only meaningful for a non-zero mask.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Parameterised first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties FIFO)
//   i_wr_en, i_din  push request and data (ignored when full, unless popping)
//   i_rd_en         pop request (ignored when empty)
//   o_dout          head entry, valid whenever o_empty = 0
//   o_empty, o_full status flags
//   o_count         number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_wr;
  logic w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;

  // A push at full is legal only together with a pop, which frees the slot.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  // Head is read combinationally so data appears together with !o_empty.
  assign o_dout = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_sequencer.sv
// ---------------------------------------------------------------------------
// adc_frame_sequencer
// Wishbone master for the 4-channel sigma-delta ADC. Enables the ADC, reads
// the masked channels on every irq and streams tagged samples out of a FIFO.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_enable, cfg_ch_mask  run request, channel select (bit i = CHi)
//   adc_irq                  ADC "all channels new" pulse
//   m_adr/m_dat_o/m_dat_i/m_we/m_sel/m_stb/m_ack  Wishbone master port
//   out_valid/out_ready/out_data/out_ch/out_last/out_err  sample stream
//   overrun_cnt              dropped frames, saturating
//   timeout_err              sticky bus timeout flag
//   busy                     FSM in a bus-owning state
// ---------------------------------------------------------------------------
module adc_frame_sequencer
  import adc_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [3:0]            cfg_ch_mask,
  input  logic                  adc_irq,
  output logic [ADDR_WIDTH-1:0] m_adr,
  output logic [31:0]           m_dat_o,
  input  logic [31:0]           m_dat_i,
  output logic                  m_we,
  output logic [3:0]            m_sel,
  output logic                  m_stb,
  input  logic                  m_ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_data,
  output logic [1:0]            out_ch,
  output logic                  out_last,
  output logic                  out_err,
  output logic [15:0]           overrun_cnt,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]          r_dat_o;
  logic                 r_we;
  logic                 r_stb;
  logic [TW-1:0]        r_to_cnt;
  logic [1:0]           r_ch;
  logic [3:0]           r_remain;     // frame mask, channels still to read
  logic                 r_pending;
  logic [15:0]          r_overrun;
  logic                 r_timeout_err;

  logic                 w_ack;
  logic                 w_timeout;
  logic                 w_bus_done;
  logic [3:0]           w_remain_after;
  logic                 w_last;
  logic                 w_push;
  sample_entry_t        w_push_entry;
  sample_entry_t        w_head;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [CW-1:0]        w_fifo_count;
  logic [CW-1:0]        w_free;
  logic                 w_fits;
  logic                 w_irq_accept;
  logic                 w_busy_state;
  logic                 w_ovr_inc;
  logic [1:0]           w_first_ch;
  logic [1:0]           w_next_ch;
  logic [ADDR_WIDTH-1:0] w_first_adr;
  logic [ADDR_WIDTH-1:0] w_next_adr;
  logic                 w_unused_hi;

  // Only the low half of each data register carries the sample.
  assign w_unused_hi = ^m_dat_i[31:16];

  // An ack is only meaningful while a strobe is outstanding.
  assign w_ack      = r_stb && m_ack;
  assign w_timeout  = r_stb && !m_ack && (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_bus_done = w_ack || w_timeout;

  assign w_remain_after = r_remain & ~(4'b0001 << r_ch);
  assign w_last         = (w_remain_after == 4'b0000);

  assign w_push_entry.err  = w_timeout;
  assign w_push_entry.last = w_last;
  assign w_push_entry.ch   = r_ch;
  assign w_push_entry.data = w_timeout ? 16'h0000 : m_dat_i[15:0];

  // Reset in the same cycle as the ack suppresses the FIFO write.
  assign w_push = (r_state == ST_RD) && w_bus_done && !rst && !w_fifo_full;

  assign w_free = CW'(FIFO_DEPTH) - w_fifo_count;
  assign w_fits = (w_free >= CW'(popcount4(cfg_ch_mask)));

  assign w_irq_accept = adc_irq || r_pending;
  assign w_busy_state = (r_state != ST_IDLE) && (r_state != ST_WAIT_IRQ);

  assign w_first_ch  = lowest_set(cfg_ch_mask);
  assign w_next_ch   = lowest_set(r_remain);
  assign w_first_adr = ADDR_WIDTH'(REG_DATA_CH0 + REG_DATA_STRIDE * {6'b0, w_first_ch});
  assign w_next_adr  = ADDR_WIDTH'(REG_DATA_CH0 + REG_DATA_STRIDE * {6'b0, w_next_ch});

  // Overrun: a frame refused for lack of space, or an irq arriving while
  // another one is already waiting.
  assign w_ovr_inc = ((r_state == ST_WAIT_IRQ) && cfg_enable && w_irq_accept &&
                      (cfg_ch_mask != 4'b0000) && !w_fits) ||
                     (w_busy_state && adc_irq && r_pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_adr         <= '0;
      r_dat_o       <= '0;
      r_we          <= 1'b0;
      r_stb         <= 1'b0;
      r_to_cnt      <= '0;
      r_ch          <= '0;
      r_remain      <= '0;
      r_pending     <= 1'b0;
      r_overrun     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_stb && !w_bus_done) ? r_to_cnt + 1'b1 : '0;

      if (w_ovr_inc && (r_overrun != 16'hFFFF)) r_overrun <= r_overrun + 16'd1;
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_busy_state && adc_irq) r_pending <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (cfg_enable) begin
            r_state <= ST_EN_WR;
            r_adr   <= ADDR_WIDTH'(REG_CTRL);
            r_dat_o <= 32'd1;
            r_we    <= 1'b1;
            r_stb   <= 1'b1;
          end
        end
        ST_EN_WR: begin
          if (w_bus_done) begin
            r_state <= ST_WAIT_IRQ;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_dat_o <= '0;
          end
        end
        ST_WAIT_IRQ: begin
          if (!cfg_enable) begin
            r_state <= ST_DIS_WR;
            r_adr   <= ADDR_WIDTH'(REG_CTRL);
            r_dat_o <= 32'd0;
            r_we    <= 1'b1;
            r_stb   <= 1'b1;
          end else if (w_irq_accept) begin
            // A fresh irq coinciding with a pending one stays pending.
            r_pending <= adc_irq && r_pending;
            if ((cfg_ch_mask != 4'b0000) && w_fits) begin
              r_state  <= ST_RD;
              r_remain <= cfg_ch_mask;
              r_ch     <= w_first_ch;
              r_adr    <= w_first_adr;
              r_we     <= 1'b0;
              r_stb    <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (w_bus_done) begin
            r_state  <= ST_RD_GAP;
            r_stb    <= 1'b0;
            r_remain <= w_remain_after;
          end
        end
        ST_RD_GAP: begin
          if (r_remain == 4'b0000) begin
            r_state <= ST_WAIT_IRQ;
          end else begin
            r_state <= ST_RD;
            r_ch    <= w_next_ch;
            r_adr   <= w_next_adr;
            r_stb   <= 1'b1;
          end
        end
        ST_DIS_WR: begin
          if (w_bus_done) begin
            r_state <= ST_IDLE;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr_en (w_push),
    .i_din   (w_push_entry),
    .i_rd_en (out_ready),
    .o_dout  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  assign m_adr       = r_adr;
  assign m_dat_o     = r_dat_o;
  assign m_we        = r_we;
  assign m_sel       = 4'hF;
  assign m_stb       = r_stb;
  assign out_valid   = !w_fifo_empty;
  assign out_data    = w_head.data;
  assign out_ch      = w_head.ch;
  assign out_last    = w_head.last;
  assign out_err     = w_head.err;
  assign overrun_cnt = r_overrun;
  assign timeout_err = r_timeout_err;
  assign busy        = w_busy_state;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_frame_sequencer
// Scoreboard bench: expected bus cycles and stream entries are queued when
// stimulus is applied and compared when the DUT completes them.
// ---------------------------------------------------------------------------
module tb_adc_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [3:0]  cfg_ch_mask;
  logic        adc_irq;
  logic [7:0]  m_adr;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        m_stb;
  logic        m_ack;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        out_err;
  logic [15:0] overrun_cnt;
  logic        timeout_err;
  logic        busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adc_frame_sequencer #(
    .ADDR_WIDTH (8),
    .FIFO_DEPTH (8),
    .TIMEOUT    (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_enable  (cfg_enable),
    .cfg_ch_mask (cfg_ch_mask),
    .adc_irq     (adc_irq),
    .m_adr       (m_adr),
    .m_dat_o     (m_dat_o),
    .m_dat_i     (m_dat_i),
    .m_we        (m_we),
    .m_sel       (m_sel),
    .m_stb       (m_stb),
    .m_ack       (m_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .out_err     (out_err),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
  } bus_t;

  bus_t        exp_bus[$];
  logic [19:0] exp_str[$];
  logic [15:0] ch_data [4];
  int          withhold_ch = -1;
  int          stb_rise_q[$];
  int          valid_cyc = -1;
  int          to_len = 0;
  int          exp_ovr = 0;

  // Slave: acks in the second strobe cycle, optionally withholds one channel.
  initial begin : slave
    int   cnt;
    bit   acked;
    bit   hold;
    int   ch;
    bus_t b;
    cnt = 0; acked = 0;
    m_ack = 1'b0; m_dat_i = '0;
    forever begin
      @(negedge clk);
      if (m_stb) begin
        cnt++;
        if (cnt == 1) stb_rise_q.push_back(cyc);
        hold = (withhold_ch >= 0) && !m_we && (m_adr == 8'(8 + 4 * withhold_ch));
        if (cnt == 2 && !hold) begin
          m_ack = 1'b1;
          acked = 1;
          ch = (int'(m_adr) - 8) >>> 2;
          m_dat_i = {16'(cyc) ^ 16'hA5C3, (ch >= 0 && ch < 4) ? ch_data[ch] : 16'h0};
          $display("bus %s adr=0x%02h wdat=0x%08h", m_we ? "WR" : "RD", m_adr, m_dat_o);
          chk("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
          chk("bus_sel", 32'(m_sel), 32'hF);
          if (exp_bus.size() != 0) begin
            b = exp_bus.pop_front();
            chk("bus_we", 32'(m_we), 32'(b.we));
            chk("bus_adr", 32'(m_adr), 32'(b.adr));
            if (b.we) chk("bus_wdat", m_dat_o, b.dat);
          end
        end else begin
          m_ack = 1'b0;
        end
      end else begin
        if (cnt > 0 && !acked) begin
          to_len = cnt;
          $display("bus timeout after %0d strobe cycles", cnt);
        end
        cnt = 0; acked = 0; m_ack = 1'b0;
      end
    end
  end

  // Stream consumer monitor.
  initial begin : stream_mon
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && valid_cyc < 0) valid_cyc = cyc;
      if (!rst && out_valid && out_ready) begin
        $display("stream ch=%0d data=0x%04h last=%0d err=%0d", out_ch, out_data, out_last, out_err);
        chk("str_expected", 32'(exp_str.size() != 0), 32'd1);
        if (exp_str.size() != 0) begin
          e = exp_str.pop_front();
          chk("str_entry", {12'b0, out_err, out_last, out_ch, out_data}, {12'b0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq();
    adc_irq = 1'b1;
    tick(1);
    adc_irq = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int left;
    left = budget;
    tick(3);
    while ((busy || exp_bus.size() != 0) && left > 0) begin
      tick(1);
      left--;
    end
    chk({tag, "_idle"}, 32'(left > 0), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int left;
    left = budget;
    while (exp_str.size() != 0 && left > 0) begin
      tick(1);
      left--;
    end
    chk({tag, "_drain"}, 32'(left > 0), 32'd1);
  endtask

  task automatic push_frame(input logic [3:0] mask, input int hold);
    bus_t b;
    bit   last;
    bit   err;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        last = ((mask >> (c + 1)) == 4'b0000);
        err  = (c == hold);
        if (!err) begin
          b.we = 1'b0; b.adr = 8'(8 + 4 * c); b.dat = '0;
          exp_bus.push_back(b);
        end
        exp_str.push_back({err, last, 2'(c), err ? 16'h0000 : ch_data[c]});
      end
    end
  endtask

  task automatic push_wr(input logic [31:0] d);
    bus_t b;
    b.we = 1'b1; b.adr = 8'h00; b.dat = d;
    exp_bus.push_back(b);
  endtask

  initial begin : driver
    int t0;
    int left;
    rst = 1'b1; cfg_enable = 1'b0; cfg_ch_mask = 4'h0; adc_irq = 1'b0; out_ready = 1'b1;
    ch_data[0] = 16'h1111; ch_data[1] = 16'h2222; ch_data[2] = 16'h3333; ch_data[3] = 16'h4444;
    tick(4);
    chk("rst_stb", 32'(m_stb), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun_cnt), 32'd0);
    chk("rst_toerr", 32'(timeout_err), 32'd0);
    chk("rst_adr", 32'(m_adr), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: enable, full frame, latency
    cfg_ch_mask = 4'hF;
    push_wr(32'd1);
    cfg_enable = 1'b1;
    wait_idle(40, "t1_en");
    push_frame(4'hF, -1);
    stb_rise_q.delete();
    valid_cyc = -1;
    t0 = cyc;
    pulse_irq();
    wait_idle(60, "t1");
    wait_drain(20, "t1");
    chk("t1_stb_count", 32'(stb_rise_q.size()), 32'd4);
    if (stb_rise_q.size() >= 2) begin
      chk("t1_stb_lat", 32'(stb_rise_q[0] - t0), 32'd1);
      chk("t1_stb2_lat", 32'(stb_rise_q[1] - t0), 32'd4);
    end
    chk("t1_valid_lat", 32'(valid_cyc - t0), 32'd3);

    // 2: sparse mask
    cfg_ch_mask = 4'b1010;
    ch_data[1] = 16'h1234; ch_data[3] = 16'hBEEF;
    push_frame(4'b1010, -1);
    pulse_irq();
    wait_idle(60, "t2");
    wait_drain(20, "t2");

    // mask 0: irq consumed silently
    cfg_ch_mask = 4'b0000;
    pulse_irq();
    wait_idle(20, "m0");
    chk("m0_ovr", 32'(overrun_cnt), 32'(exp_ovr));

    // 3: consumer stalled, third frame has no room
    out_ready = 1'b0;
    cfg_ch_mask = 4'hF;
    ch_data[0] = 16'h0A0A; ch_data[2] = 16'hC0DE;
    push_frame(4'hF, -1);
    pulse_irq();
    wait_idle(60, "t3a");
    push_frame(4'hF, -1);
    pulse_irq();
    wait_idle(60, "t3b");
    pulse_irq();
    exp_ovr++;
    wait_idle(20, "t3c");
    chk("t3_ovr", 32'(overrun_cnt), 32'(exp_ovr));
    chk("t3_full_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_drain(40, "t3");

    // 4: pending irq, then one more while pending
    push_frame(4'hF, -1);
    push_frame(4'hF, -1);
    pulse_irq();
    tick(2);
    pulse_irq();
    tick(2);
    pulse_irq();
    exp_ovr++;
    wait_idle(100, "t4");
    wait_drain(20, "t4");
    chk("t4_ovr", 32'(overrun_cnt), 32'(exp_ovr));

    // 5: CH2 never acked
    chk("t5_toerr_before", 32'(timeout_err), 32'd0);
    withhold_ch = 2;
    to_len = 0;
    push_frame(4'hF, 2);
    pulse_irq();
    wait_idle(150, "t5");
    wait_drain(20, "t5");
    chk("t5_stb_len", 32'(to_len), 32'd15);
    chk("t5_toerr", 32'(timeout_err), 32'd1);
    withhold_ch = -1;

    // 6a: disable mid-frame
    push_frame(4'hF, -1);
    push_wr(32'd0);
    pulse_irq();
    tick(3);
    cfg_enable = 1'b0;
    wait_idle(80, "t6a");
    wait_drain(20, "t6a");
    tick(2);
    chk("t6a_busy", 32'(busy), 32'd0);
    chk("t6a_stb", 32'(m_stb), 32'd0);

    // 6b: reset during the CH1 read
    push_wr(32'd1);
    cfg_enable = 1'b1;
    wait_idle(40, "t6b_en");
    out_ready = 1'b0;
    begin
      bus_t b;
      b.we = 1'b0; b.adr = 8'h08; b.dat = '0;
      exp_bus.push_back(b);
    end
    pulse_irq();
    left = 30;
    while (!(m_stb && m_adr == 8'h0C) && left > 0) begin
      tick(1);
      left--;
    end
    chk("t6b_reach_ch1", 32'(left > 0), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("t6b_stb", 32'(m_stb), 32'd0);
    chk("t6b_valid", 32'(out_valid), 32'd0);
    chk("t6b_busy", 32'(busy), 32'd0);
    chk("t6b_toerr", 32'(timeout_err), 32'd0);
    chk("t6b_ovr", 32'(overrun_cnt), 32'd0);
    chk("t6b_bus_left", 32'(exp_bus.size()), 32'd0);
    exp_str.delete();
    exp_bus.delete();
    cfg_enable = 1'b0;
    tick(1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(5);
    chk("t6b_quiet_stb", 32'(m_stb), 32'd0);
    chk("t6b_quiet_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
